mac_seq_fp32: RTL
=================

# mac_seq_fp32

Streaming FP32 dot-product sequencer that acts as the initiator for a combinational fused multiply-add unit. It accepts operand pairs on a valid/ready stream, drives the MAC operand and rounding ports with the running accumulator fed back as the addend, and returns one result per vector on an output valid/ready stream. It sits between the operand-fetch logic and the single-cycle FP32 MAC in the datapath.

## Interface
- N_SIG, 23, significand width of the MAC operands
- N_EXP, 8, exponent width
- N_DATA, N_EXP+N_SIG+1, operand/result width
- CNT_W, 16, width of the per-vector beat counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; one clock; asynchronous, active-low
- rnd  in  3  rounding mode; must be stable while a vector is in progress
- flush  in  1  synchronous abort of the current vector
- s_valid  in  1  operand beat valid
- s_ready  out  1  operand beat accepted when s_valid & s_ready
- s_a, s_b  in  N_DATA  multiplicands
- s_last  in  1  final beat of the vector
- mac_a, mac_b, mac_c  out  N_DATA  MAC operands (product a*b plus addend c)
- mac_rnd  out  3  MAC rounding mode
- mac_z  in  N_DATA  MAC result, combinational from mac_a/b/c/rnd
- mac_status  in  8  MAC status flags (bit0 zero, 1 infinity, 2 invalid, 3 tiny, 4 huge, 5 inexact, 7:6 reserved)
- m_valid  out  1  result valid
- m_ready  in  1  result accepted when m_valid & m_ready
- m_result  out  N_DATA  dot-product result
- m_status  out  8  accumulated status of the vector
- m_count  out  CNT_W  beats accepted in the vector, saturating

## Operation
- States: ACC (accepting beats) and DONE (holding result). Reset state ACC.
- Registers: acc (N_DATA), stat (8), cnt (CNT_W).
- mac_a = s_a, mac_b = s_b, mac_c = acc, mac_rnd = rnd at all times.
- ACC: s_ready = ~flush. On accepted beat: acc <= mac_z; stat[7:1] <= stat[7:1] | mac_status[7:1]; stat[0] <= mac_status[0]; cnt <= cnt+1, holding at 2^CNT_W-1 when saturated. If s_last, go to DONE.
- DONE: s_ready = 0; m_valid = 1; m_result = acc; m_status = stat; m_count = cnt. On m_ready: acc <= 0x00000000 (+0.0), stat <= 0, cnt <= 0, go to ACC.
- flush (any state): acc, stat, cnt cleared, state <= ACC, any concurrent beat dropped (s_ready is low) and any pending result discarded. flush has priority over m_ready and s_valid.
- Single-beat vector (s_last on first beat): result = a*b + (+0.0), rounded once by the MAC.
- No special-value handling in this block; NaN/Inf propagate through the MAC feedback unchanged.

## Timing
- Reset values: state ACC, acc 0, stat 0, cnt 0; m_valid 0, m_result 0, m_status 0, m_count 0, s_ready 1 (with flush low).
- Throughput: one beat per cycle in ACC; a vector of N beats takes N cycles of acceptance.
- Latency: m_valid asserts the cycle after the s_last beat is accepted.
- Result handoff costs one cycle: the cycle m_ready is seen in DONE, no beat is accepted; s_ready rises the next cycle.
- m_result/m_status/m_count are held stable while m_valid & ~m_ready.
- Asynchronous reset mid-vector: all state cleared immediately; partial vector lost.
- s_valid low in ACC: no state change; gaps between beats are allowed.

## Test plan
- Vector (1.0,3.0),(2.0,4.0): s_a 0x3F800000,0x40000000; s_b 0x40400000,0x40800000, s_last on beat 2 -> m_valid the next cycle, m_result 0x41300000 (11.0), m_count 2, m_status[5] 0.
- Single beat 0x3F000000 * 0x40000000, s_last -> m_result 0x3F800000, m_count 1; m_ready held low 5 cycles -> outputs stable, s_ready 0 throughout.
- Overflow: 0x7F7FFFFF * 0x40000000, then 0x3F800000 * 0x3F800000 last -> m_result 0x7F800000, m_status bits 1, 4, 5 set (sticky).
- Invalid: 0x7F800000 * 0x00000000 last -> m_result quiet NaN (exponent all ones, nonzero fraction), m_status[2] 1.
- flush asserted on the cycle of beat 3 of a 4-beat vector, then a new vector (1.0,1.0) last -> beat 3 not accepted, no result for the aborted vector, next result 0x3F800000, m_count 1.
- Back-to-back vectors with m_ready held high and continuous s_valid -> one dead cycle per vector, acc restarts from +0.0 each vector; rst_n pulsed mid-vector -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/mac_seq_fp32.sv
// Streaming FP32 dot-product sequencer: feeds operand pairs to an external combinational
// FMA with the running accumulator as addend, and returns one result per vector.
module mac_seq_fp32 #(
    parameter int N_SIG  = 23,
    parameter int N_EXP  = 8,
    parameter int N_DATA = N_EXP + N_SIG + 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        rnd,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [N_DATA-1:0] s_a,
    input  logic [N_DATA-1:0] s_b,
    input  logic              s_last,
    output logic [N_DATA-1:0] mac_a,
    output logic [N_DATA-1:0] mac_b,
    output logic [N_DATA-1:0] mac_c,
    output logic [2:0]        mac_rnd,
    input  logic [N_DATA-1:0] mac_z,
    input  logic [7:0]        mac_status,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_DATA-1:0] m_result,
    output logic [7:0]        m_status,
    output logic [CNT_W-1:0]  m_count
);

    typedef enum logic {ST_ACC = 1'b0, ST_DONE = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_q, state_d;
    logic [N_DATA-1:0]   acc_q, acc_d;
    logic [7:0]          stat_q, stat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                beat;

    // The accumulator is the addend of every product, so the MAC sees the running sum.
    assign mac_a   = s_a;
    assign mac_b   = s_b;
    assign mac_c   = acc_q;
    assign mac_rnd = rnd;

    assign s_ready  = (state_q == ST_ACC) && !flush;
    assign beat     = s_valid && s_ready;
    assign m_valid  = (state_q == ST_DONE);
    assign m_result = acc_q;
    assign m_status = stat_q;
    assign m_count  = cnt_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_ACC;
            acc_d   = '0;
            stat_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (beat) begin
                        acc_d  = mac_z;
                        // Bit 0 (zero) describes only the latest sum; the rest are sticky.
                        stat_d = {stat_q[7:1] | mac_status[7:1], mac_status[0]};
                        cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                        if (s_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (m_ready) begin
                        state_d = ST_ACC;
                        acc_d   = '0;
                        stat_d  = '0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            stat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
